// File: rtl/sram_if.sv
// SRAM request bus between the processor controller (master) and the
// SRAM responder (slave). Request fields are driven by the controller.
// Read data comes back one cycle later on sram_DO.
interface sram_if;
    logic [15:0] sram_ADDR;
    logic [31:0] sram_DI;
    logic        sram_EN;
    logic        sram_WE;
    logic [31:0] sram_DO;

    modport master (
        output sram_ADDR, sram_DI, sram_EN, sram_WE,
        input  sram_DO
    );

    modport slave (
        input  sram_ADDR, sram_DI, sram_EN, sram_WE,
        output sram_DO
    );
endinterface

// File: rtl/sram_responder.sv
// Single-port synchronous SRAM responder.
// It owns the word array `mem` and returns registered read data one cycle
// after a read request. Accesses at or beyond DEPTH set a sticky error flag.
// An out-of-range read returns RD_OOR_VAL.
//
// Optional feature macro: SRAM_CLEAR_EN
//   defined   : after every reset a CLEAR state zeroes the array one word per
//               edge. init_done rises on the edge that clears word DEPTH-1.
//   undefined : no clear sequencer. The array keeps its contents across reset,
//               and init_done rises at the first edge after reset is released.
module sram_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] RD_OOR_VAL = 32'hDEADBEEF
) (
    input  logic  clk,
    input  logic  reset_n,
    sram_if.slave bus,
    output logic  init_done,
    output logic  oor_err
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    // Hierarchical halt-time dumps read this array by name.
    logic [31:0] mem [DEPTH];

    logic          ready;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          rd_req;
    logic          wr_req;
    logic          clr_we;
    logic [AW-1:0] clr_idx;

    // The compare is done at 17 bits so that DEPTH = 65536 still works.
    assign in_range = ({1'b0, bus.sram_ADDR} < DEPTH_W);
    assign idx      = bus.sram_ADDR[AW-1:0];

    // Requests are accepted only when out of reset and in READY.
    // A request issued during reset or CLEAR is dropped.
    assign rd_req = reset_n && ready && bus.sram_EN && !bus.sram_WE;
    assign wr_req = reset_n && ready && bus.sram_EN &&  bus.sram_WE;

`ifdef SRAM_CLEAR_EN
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] clr_addr;

    // State register: reset always restarts the clear sequence.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!reset_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave CLEAR on the edge that clears the last word.
    always_comb begin
        // NOTE: assign a default before the case so that no path leaves
        // state_nxt unassigned. An unassigned path would infer a latch.
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_addr == 16'(DEPTH - 1)) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = CLEAR;
        endcase
    end

    // Clear address counter: walks 0..DEPTH-1 while in CLEAR.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 16'd1;
        end
    end

    assign ready     = (state == READY);
    assign init_done = ready;
    assign clr_we    = reset_n && (state == CLEAR);
    assign clr_idx   = clr_addr[AW-1:0];
`else
    // Ready flag: the responder is usable from the first edge after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
        end
    end

    assign ready   = init_done;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    // Array write port: clear writes take priority, then in-range requests.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch. Reset must not disturb its
        // contents, and leaving the reset out keeps it mappable to RAM macros.
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_req && in_range) begin
            mem[idx] <= bus.sram_DI;
        end
    end

    // Read data register: updated only by reads and held otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.sram_DO <= '0;
        end else if (rd_req) begin
            bus.sram_DO <= in_range ? mem[idx] : RD_OOR_VAL;
        end
    end

    // Sticky out-of-range flag: only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            oor_err <= 1'b0;
        end else if ((rd_req || wr_req) && !in_range) begin
            oor_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed testbench for sram_responder.
// With SRAM_CLEAR_EN defined, it uses DEPTH = 16 and exercises the clear
// sequencer. Otherwise it uses DEPTH = 1024 and checks that memory
// contents survive reset.
module tb_sram_responder;

`ifdef SRAM_CLEAR_EN
    localparam int unsigned D = 16;
`else
    localparam int unsigned D = 1024;
`endif
    localparam logic [15:0] ADDR_OOR   = 16'(D);
    localparam logic [15:0] ADDR_LAST  = 16'(D - 1);
    localparam logic [15:0] ADDR_2000  = 16'd2000;
    localparam logic [15:0] ADDR_ALIAS = 16'(2000 % D);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic init_done;
    logic oor_err;

    sram_if bus ();

    sram_responder #(
        .DEPTH      (D),
        .RD_OOR_VAL (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .init_done (init_done),
        .oor_err   (oor_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.sram_EN = 1'b0;
        bus.sram_WE = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        bus.sram_ADDR = a;
        bus.sram_DI   = d;
        bus.sram_EN   = 1'b1;
        bus.sram_WE   = 1'b1;
        tick();
        idle();
    endtask

    task automatic rd(input logic [15:0] a);
        bus.sram_ADDR = a;
        bus.sram_EN   = 1'b1;
        bus.sram_WE   = 1'b0;
        tick();
        idle();
    endtask

    // One reset edge with an out-of-range read presented at the same time.
    // The reset must win, so sram_DO and oor_err return to zero.
    task automatic do_reset();
        reset_n       = 1'b0;
        bus.sram_ADDR = ADDR_OOR;
        bus.sram_EN   = 1'b1;
        bus.sram_WE   = 1'b0;
        tick();
        idle();
        check("rst_do", bus.sram_DO, 32'h0);
        check("rst_oor", {31'b0, oor_err}, 32'h0);
        check("rst_init", {31'b0, init_done}, 32'h0);
        reset_n = 1'b1;
    endtask

    // Wait out the post-reset bring-up and check exactly when init_done rises.
    task automatic wait_ready(input string tag);
`ifdef SRAM_CLEAR_EN
        for (int i = 1; i < int'(D); i++) begin
            tick();
            check({tag, "_busy"}, {31'b0, init_done}, 32'h0);
        end
        tick();
        check({tag, "_done"}, {31'b0, init_done}, 32'h1);
`else
        check({tag, "_pre"}, {31'b0, init_done}, 32'h0);
        tick();
        check({tag, "_done"}, {31'b0, init_done}, 32'h1);
`endif
    endtask

    initial begin
        bus.sram_ADDR = '0;
        bus.sram_DI   = '0;
        idle();

        do_reset();
        wait_ready("boot");

        // Read after write, then hold with EN=0.
        wr(16'd5, 32'h12345678);
        rd(16'd5);
        check("raw_n2", bus.sram_DO, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("raw_hold", bus.sram_DO, 32'h12345678);
        end

        // Back-to-back reads at full rate.
        wr(16'd0, 32'hA);
        wr(16'd1, 32'hB);
        bus.sram_ADDR = 16'd0;
        bus.sram_EN   = 1'b1;
        bus.sram_WE   = 1'b0;
        tick();
        check("b2b_0", bus.sram_DO, 32'hA);
        bus.sram_ADDR = 16'd1;
        tick();
        idle();
        check("b2b_1", bus.sram_DO, 32'hB);

        // Highest legal address.
        wr(ADDR_LAST, 32'h0F0F0F0F);
        rd(ADDR_LAST);
        check("last_word", bus.sram_DO, 32'h0F0F0F0F);

        // Out-of-range read and write.
        wr(ADDR_ALIAS, 32'hCAFE0001);
        check("oor_clean", {31'b0, oor_err}, 32'h0);
        rd(ADDR_OOR);
        check("oor_rd_do", bus.sram_DO, 32'hDEADBEEF);
        check("oor_rd_flag", {31'b0, oor_err}, 32'h1);
        rd(16'd5);
        check("oor_then_ok", bus.sram_DO, 32'h12345678);
        wr(ADDR_2000, 32'hBAD0BAD0);
        check("oor_wr_do", bus.sram_DO, 32'h12345678);
        rd(ADDR_ALIAS);
        check("oor_no_alias", bus.sram_DO, 32'hCAFE0001);
        rd(16'hFFFF);
        check("oor_ffff", bus.sram_DO, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) tick();
        check("oor_sticky", {31'b0, oor_err}, 32'h1);

`ifdef SRAM_CLEAR_EN
        // Full clear of an all-ones array.
        for (int i = 0; i < int'(D); i++) wr(16'(i), 32'hFFFFFFFF);
        rd(16'd3);
        check("ones_loaded", bus.sram_DO, 32'hFFFFFFFF);
        do_reset();
        wait_ready("clr");
        for (int i = 0; i < int'(D); i++) begin
            rd(16'(i));
            check("clr_word", bus.sram_DO, 32'h0);
        end

        // Reset in the middle of a clear, with a read issued during CLEAR.
        for (int i = 0; i < int'(D); i++) wr(16'(i), 32'hFFFFFFFF);
        do_reset();
        bus.sram_ADDR = 16'd3;
        bus.sram_EN   = 1'b1;
        bus.sram_WE   = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        idle();
        check("mid_busy", {31'b0, init_done}, 32'h0);
        check("mid_rd_ignored", bus.sram_DO, 32'h0);
        do_reset();
        wait_ready("restart");
        for (int i = 0; i < int'(D); i++) begin
            rd(16'(i));
            check("restart_word", bus.sram_DO, 32'h0);
        end
`else
        // Contents survive reset when there is no clear sequencer.
        wr(16'd2, 32'h55);
        do_reset();
        wait_ready("noclr");
        rd(16'd2);
        check("noclr_keep", bus.sram_DO, 32'h55);
        rd(16'd5);
        check("noclr_keep5", bus.sram_DO, 32'h12345678);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
